// File: rtl/reg_file_if.sv
// reg_file_if: read/write port bundle for the register file.
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] Rreg1, Rreg2, regNum;
    logic [DATA_W-1:0] Rdata1, Rdata2, wrdata;
    logic              enwr;
    modport master (output Rreg1, Rreg2, enwr, wrdata, regNum, input Rdata1, Rdata2);
    modport slave  (input Rreg1, Rreg2, enwr, wrdata, regNum, output Rdata1, Rdata2);
endinterface

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, two async read ports, one write port, r0 fixed at zero.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic       clk,
    input logic       rst_n,
    reg_file_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs [NREG];
    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        else if (bus.enwr && bus.regNum != '0)
            regs[bus.regNum] <= bus.wrdata;
    end
    assign bus.Rdata1 = regs[bus.Rreg1];
    assign bus.Rdata2 = regs[bus.Rreg2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and randomized checks of reg_file against an array model.
module tb_reg_file;
    logic clk = 0;
    logic rst_n = 0;
    int checks = 0;
    int failures = 0;
    logic [31:0] model [32];
    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.enwr = 1; bus.regNum = a; bus.wrdata = d;
        @(posedge clk); #1;
        if (a != 0) model[a] = d;
        bus.enwr = 0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        bus.Rreg1 = a; bus.Rreg2 = b;
        #1;
    endtask

    task automatic scan_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            chk(tag, bus.Rdata1, model[i]);
            chk(tag, bus.Rdata2, model[31 - i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        bus.enwr = 0; bus.regNum = '0; bus.wrdata = '0;
        rd(10, 19);
        chk("reset_r10", bus.Rdata1, 32'h0);
        chk("reset_r19", bus.Rdata2, 32'h0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        wr(10, 64); wr(14, 31); wr(19, 45);
        rd(10, 14);
        chk("wr_r10", bus.Rdata1, 32'h40);
        chk("wr_r14", bus.Rdata2, 32'h1F);
        bus.regNum = 'x; bus.wrdata = 'x;
        rd(19, 0);
        @(posedge clk); #1;
        chk("x_r19", bus.Rdata1, 32'h2D);
        chk("x_r0", bus.Rdata2, 32'h0);
        scan_all("x_hold");
        wr(0, 32'hFFFF_FFFF);
        wr(31, 32'hDEAD_BEEF);
        rd(0, 31);
        chk("r0_zero", bus.Rdata1, 32'h0);
        chk("r31_full", bus.Rdata2, 32'hDEAD_BEEF);
        rd(5, 5);
        bus.enwr = 1; bus.regNum = 5; bus.wrdata = 7; #1;
        chk("rdw_old", bus.Rdata1, model[5]);
        @(posedge clk); #1;
        model[5] = 7; bus.enwr = 0;
        chk("rdw_new", bus.Rdata1, 32'h7);
        chk("rdw_port2", bus.Rdata2, 32'h7);
        for (int n = 0; n < 300; n++) begin
            logic en;
            logic [4:0] a;
            logic [31:0] d;
            en = 1'($urandom);
            a = 5'($urandom);
            d = $urandom;
            bus.enwr = en; bus.regNum = a; bus.wrdata = d;
            rd(($urandom_range(0, 3) == 0) ? a : 5'($urandom), 5'($urandom));
            chk("rnd_p1", bus.Rdata1, model[bus.Rreg1]);
            chk("rnd_p2", bus.Rdata2, model[bus.Rreg2]);
            @(posedge clk); #1;
            if (en && a != 0) model[a] = d;
        end
        bus.enwr = 0;
        scan_all("rnd_final");
        #2 rst_n = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        scan_all("async_rst");
        bus.enwr = 1; bus.regNum = 10; bus.wrdata = 32'h55;
        @(posedge clk); #1;
        rd(10, 10);
        chk("rst_blocks_wr", bus.Rdata1, 32'h0);
        bus.enwr = 0;
        #2 rst_n = 1;
        rd(10, 3);
        chk("post_rst_r10", bus.Rdata1, 32'h0);
        wr(10, 32'h1234);
        rd(10, 3);
        chk("post_rst_wr", bus.Rdata1, 32'h1234);
        bus.enwr = 1; bus.regNum = 3; bus.wrdata = 32'hAAAA_5555;
        @(posedge clk); rst_n = 0;
        #1 bus.enwr = 0;
        model[10] = 0;
        rd(3, 10);
        chk("coinc_r3", bus.Rdata1, 32'h0);
        chk("coinc_r10", bus.Rdata2, 32'h0);
        @(negedge clk); rst_n = 1;
        wr(3, 32'h0BAD_F00D);
        rd(3, 10);
        chk("first_wr_r3", bus.Rdata1, 32'h0BAD_F00D);
        chk("first_wr_r10", bus.Rdata2, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, using the ports clk and rst_n.
REQ-002 Parameter DATA_W, default 32, SHALL set the register and data-port width in bits.
REQ-003 Parameter ADDR_W, default 5, SHALL set the register-index width; the register count SHALL be 2**ADDR_W (32 by default).
REQ-004 clk  input  1  SHALL be the clock; all register writes occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-006 Rreg1  input  ADDR_W  SHALL be the read-port-1 register index.
REQ-007 Rreg2  input  ADDR_W  SHALL be the read-port-2 register index.
REQ-008 Rdata1  output  DATA_W  SHALL be the read-port-1 data.
REQ-009 Rdata2  output  DATA_W  SHALL be the read-port-2 data.
REQ-010 enwr  input  1  SHALL be the write enable: 1 = write, 0 = read-only cycle.
REQ-011 wrdata  input  DATA_W  SHALL be the write data.
REQ-012 regNum  input  ADDR_W  SHALL be the write-destination register index.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits each.
REQ-014 Register 0 SHALL be hardwired to zero: reads of index 0 return 0, and writes to index 0 are discarded.
REQ-015 On a rising clk edge with rst_n=1 and enwr=1, register[regNum] SHALL take the value wrdata (write latency: 1 clock).
REQ-016 When enwr=0, no register SHALL change, and regNum and wrdata SHALL be ignored, including X or Z values.
REQ-017 Rdata1 SHALL combinationally equal register[Rreg1] with zero clock latency; Rdata2 SHALL do the same for Rreg2.
REQ-018 Both read ports SHALL be independent and SHALL be usable simultaneously, including on the same index.
REQ-019 Read during write to the same index SHALL return the old value until the clock edge, with no write-to-read bypass; the new value appears after the edge.
REQ-020 Only one register SHALL be written per clock, and all other registers SHALL hold their values.
REQ-021 Data SHALL be stored and returned unmodified at full DATA_W width, with no sign extension or truncation.

Reset
REQ-022 When rst_n=0, all registers SHALL clear to 0 asynchronously, without waiting for a clk edge.
REQ-023 While rst_n=0, writes SHALL be blocked, and Rdata1 and Rdata2 SHALL read 0 for every index.
REQ-024 A write edge coinciding with reset assertion SHALL be lost, and the register SHALL read 0.
REQ-025 After rst_n deasserts, the first write SHALL take effect on the first rising clk edge at which rst_n=1 and enwr=1.

Verification
REQ-026 Reset, then Rreg1=10 and Rreg2=19 -> Rdata1=0x00000000 and Rdata2=0x00000000.
REQ-027 Write 64 to r10, 31 to r14 and 45 to r19 (enwr=1, one per clock), then set enwr=0, Rreg1=10, Rreg2=14 -> Rdata1=0x00000040 and Rdata2=0x0000001F.
REQ-028 With enwr=0, Rreg1=19 and Rreg2=0, and regNum and wrdata driven to X -> Rdata1=0x0000002D, Rdata2=0x00000000, and no register changes.
REQ-029 Write 0xFFFFFFFF to r0 with enwr=1 -> r0 still reads 0; write 0xDEADBEEF to r31 -> r31 reads 0xDEADBEEF.
REQ-030 With Rreg1=5 and a write of 7 to r5 -> Rdata1 holds the old value before the edge and reads 7 after the edge.
REQ-031 Assert rst_n=0 mid-sequence, between clock edges -> all reads return 0 immediately; after release, r10 reads 0 until it is rewritten.
